// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and helpers for the UART pixel command path.
package uart_cmd_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam logic [7:0] REPLY_ACK = 8'h06;
  localparam logic [7:0] REPLY_NAK = 8'h15;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_COLLECT    = 3'd1;
  localparam logic [2:0] ST_CHECK      = 3'd2;
  localparam logic [2:0] ST_WRITE      = 3'd3;
  localparam logic [2:0] ST_REPLY      = 3'd4;
  localparam logic [2:0] ST_REPLY_WAIT = 3'd5;

  localparam logic [2:0] IDX_CHK = 3'd6;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [7:0] color;
  } pix_cmd_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] b1, input logic [7:0] b2,
                                           input logic [7:0] b3, input logic [7:0] b4,
                                           input logic [7:0] b5);
    return b1 ^ b2 ^ b3 ^ b4 ^ b5;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and emits a
// single-cycle expired pulse once LIMIT cycles have elapsed.
module byte_timeout_timer #(
  parameter int LIMIT = 86800
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_r;
  logic          expired_r;

  // Cycle counter with reload on clear and wrap-to-zero on expiry.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count_r   <= {CW{1'b0}};
      expired_r <= 1'b0;
    end else if (clear) begin
      count_r   <= {CW{1'b0}};
      expired_r <= 1'b0;
    end else if (enable) begin
      if (count_r == LAST) begin
        count_r   <= {CW{1'b0}};
        expired_r <= 1'b1;
      end else begin
        count_r   <= count_r + CW'(1'b1);
        expired_r <= 1'b0;
      end
    end else begin
      expired_r <= 1'b0;
    end
  end

  assign expired = expired_r;

endmodule

// File: rtl/uart_pixel_cmd_ctrl.sv
// UART pixel command controller: parses 7-byte pixel-write frames, drives the
// frame-buffer write port and answers every command with ACK or NAK.
module uart_pixel_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 868,
  parameter int TIMEOUT_BYTES = 10,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  input  logic       i_TX_Active,
  input  logic       i_TX_Done,
  output logic       o_Pix_We,
  output logic [9:0] o_Pix_X,
  output logic [8:0] o_Pix_Y,
  output logic [7:0] o_Pix_Color,
  input  logic       i_Pix_Ready,
  output logic       o_Busy,
  output logic [7:0] o_Err_Count
);

  localparam int              TIMEOUT_CYCLES = TIMEOUT_BYTES * 10 * CLKS_PER_BIT;
  localparam logic [10:0]     X_LIMIT        = 11'(H_ACTIVE);
  localparam logic [9:0]      Y_LIMIT        = 10'(V_ACTIVE);

  logic [2:0] state_r;
  logic [2:0] state_nxt_s;
  logic [2:0] idx_r;
  logic [7:0] frame_r [1:6];
  pix_cmd_t   pix_r;
  logic       pix_we_r;
  logic       tx_dv_r;
  logic [7:0] tx_byte_r;
  logic       busy_r;
  logic [7:0] err_r;

  logic       err_inc_s;
  logic       drop_s;
  logic       timeout_s;
  logic       tmr_clear_s;
  logic       tmr_enable_s;
  logic [9:0] cmd_x_s;
  logic [8:0] cmd_y_s;
  logic       cmd_ok_s;

  // Only the low bits of the high bytes address pixels; all bits feed the checksum.
  assign cmd_x_s  = {frame_r[1][1:0], frame_r[2]};
  assign cmd_y_s  = {frame_r[3][0], frame_r[4]};
  assign cmd_ok_s = (frame_chk(frame_r[1], frame_r[2], frame_r[3], frame_r[4], frame_r[5]) == frame_r[6])
                    && ({1'b0, cmd_x_s} < X_LIMIT) && ({1'b0, cmd_y_s} < Y_LIMIT);

  assign tmr_enable_s = (state_r == ST_COLLECT);
  assign tmr_clear_s  = i_RX_DV || (state_r != ST_COLLECT);

  byte_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .clear   (tmr_clear_s),
    .enable  (tmr_enable_s),
    .expired (timeout_s)
  );

  // Next-state decode plus the error events raised in each state.
  always_comb begin
    state_nxt_s = state_r;
    err_inc_s   = 1'b0;
    drop_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_RX_DV && (i_RX_Byte == FRAME_HDR)) state_nxt_s = ST_COLLECT;
        else                                      state_nxt_s = ST_IDLE;
      end
      ST_COLLECT: begin
        if (i_RX_DV) begin
          if (idx_r == IDX_CHK) state_nxt_s = ST_CHECK;
          else                  state_nxt_s = ST_COLLECT;
        end else if (timeout_s) begin
          state_nxt_s = ST_REPLY;
          err_inc_s   = 1'b1;
        end else begin
          state_nxt_s = ST_COLLECT;
        end
      end
      ST_CHECK: begin
        drop_s = i_RX_DV;
        if (cmd_ok_s) begin
          state_nxt_s = ST_WRITE;
        end else begin
          state_nxt_s = ST_REPLY;
          err_inc_s   = 1'b1;
        end
      end
      ST_WRITE: begin
        drop_s = i_RX_DV;
        if (i_Pix_Ready) state_nxt_s = ST_REPLY;
        else             state_nxt_s = ST_WRITE;
      end
      ST_REPLY: begin
        drop_s = i_RX_DV;
        if (!i_TX_Active) state_nxt_s = ST_REPLY_WAIT;
        else              state_nxt_s = ST_REPLY;
      end
      ST_REPLY_WAIT: begin
        drop_s = i_RX_DV;
        if (i_TX_Done) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_REPLY_WAIT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Frame capture, pixel write port, reply handshake and error counter.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      idx_r     <= 3'd0;
      for (int i = 1; i <= 6; i++) frame_r[i] <= 8'h00;
      pix_r     <= '{x: 10'd0, y: 9'd0, color: 8'd0};
      pix_we_r  <= 1'b0;
      tx_dv_r   <= 1'b0;
      tx_byte_r <= 8'h00;
      busy_r    <= 1'b0;
      err_r     <= 8'h00;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != ST_IDLE);
      tx_dv_r <= 1'b0;
      // A NAK and a dropped byte in the same cycle still count only once.
      if (err_inc_s || drop_s) err_r <= sat_inc(err_r);
      case (state_r)
        ST_IDLE: begin
          idx_r <= (state_nxt_s == ST_COLLECT) ? 3'd1 : 3'd0;
        end
        ST_COLLECT: begin
          if (i_RX_DV) begin
            frame_r[idx_r] <= i_RX_Byte;
            idx_r          <= idx_r + 3'd1;
          end else if (timeout_s) begin
            tx_byte_r <= REPLY_NAK;
            idx_r     <= 3'd0;
          end
        end
        ST_CHECK: begin
          idx_r <= 3'd0;
          if (cmd_ok_s) begin
            tx_byte_r <= REPLY_ACK;
            pix_we_r  <= 1'b1;
            pix_r     <= '{x: cmd_x_s, y: cmd_y_s, color: frame_r[5]};
          end else begin
            tx_byte_r <= REPLY_NAK;
          end
        end
        ST_WRITE: begin
          if (i_Pix_Ready) pix_we_r <= 1'b0;
        end
        ST_REPLY: begin
          if (!i_TX_Active) tx_dv_r <= 1'b1;
        end
        ST_REPLY_WAIT: begin
          idx_r <= 3'd0;
        end
        default: begin
          idx_r    <= 3'd0;
          pix_we_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_TX_DV     = tx_dv_r;
  assign o_TX_Byte   = tx_byte_r;
  assign o_Pix_We    = pix_we_r;
  assign o_Pix_X     = pix_r.x;
  assign o_Pix_Y     = pix_r.y;
  assign o_Pix_Color = pix_r.color;
  assign o_Busy      = busy_r;
  assign o_Err_Count = err_r;

endmodule
